mem_req_arbiter: RTL and testbench

//  Shares one sram-like master port between the CPU instruction-fetch port and data port.

---
 rtl/mem_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like master port between the fetch and data ports.
// One outstanding transaction; data first, with a fetch starvation bound.
module mem_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t            state_q, state_d;
  logic              own_i_q, own_i_d;
  logic              drop_q, drop_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic fetch_win;
  logic drop_eff;

  assign fetch_win = i_req & (~d_req | (starve_q == LIM));
  // A cancel in the same cycle as the response already hides it.
  assign drop_eff  = drop_q | (i_cancel & own_i_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      own_i_q  <= 1'b0;
      drop_q   <= 1'b0;
      starve_q <= '0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      wstrb_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_i_q  <= own_i_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    own_i_d   = own_i_q;
    drop_d    = drop_q;
    starve_d  = starve_q;
    wr_d      = wr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_req     = 1'b0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (fetch_win) begin
          own_i_d  = 1'b1;
          starve_d = '0;
          wr_d     = 1'b0;
          size_d   = 2'd2;
          wstrb_d  = 4'b0000;
          addr_d   = i_addr;
          wdata_d  = '0;
          state_d  = S_ADDR;
        end else if (d_req) begin
          own_i_d = 1'b0;
          if (i_req && starve_q != LIM)
            starve_d = starve_q + 1'b1;
          wr_d    = d_wr;
          size_d  = d_size;
          wstrb_d = d_wstrb;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        m_req = 1'b1;
        if (own_i_q && i_cancel)
          drop_d = 1'b1;
        if (m_addr_ok) begin
          i_addr_ok = own_i_q & ~drop_eff;
          d_addr_ok = ~own_i_q;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (own_i_q && i_cancel)
          drop_d = 1'b1;
        if (m_data_ok) begin
          i_data_ok = own_i_q & ~drop_eff;
          d_data_ok = ~own_i_q;
          drop_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_wstrb = wstrb_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_data_ok ? m_rdata : '0;
  assign d_rdata = d_data_ok ? m_rdata : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter.
// Drives on the falling edge, samples 1ns later.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 0, i_cancel = 0;
  logic [31:0] i_addr = '0;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req = 0, d_wr = 0;
  logic [1:0]  d_size = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok = 0, m_data_ok = 0;
  logic [31:0] m_rdata = '0;

  int asserts = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  // Downstream slave: waits for m_req, accepts it, answers next cycle.
  task automatic serve(
    input  logic [31:0] rd,
    output logic        to,
    output int          w,
    output logic [31:0] a,
    output logic        wr,
    output logic [1:0]  sz,
    output logic [3:0]  st,
    output logic [31:0] wd,
    output logic        iaok,
    output logic        daok,
    output logic        idok,
    output logic        ddok,
    output logic [31:0] ird,
    output logic [31:0] drd
  );
    to = 1; w = 0; a = '0; wr = 0; sz = '0; st = '0; wd = '0;
    iaok = 0; daok = 0; idok = 0; ddok = 0; ird = '0; drd = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m_data_ok = 0; m_addr_ok = 0;
      #1;
      if (m_req) begin
        m_addr_ok = 1;
        #1;
        a = m_addr; wr = m_wr; sz = m_size; st = m_wstrb; wd = m_wdata;
        iaok = i_addr_ok; daok = d_addr_ok;
        to = 0;
        break;
      end
      w++;
    end
    if (!to) begin
      @(negedge clk);
      m_addr_ok = 0; m_data_ok = 1; m_rdata = rd;
      #1;
      idok = i_data_ok; ddok = d_data_ok; ird = i_rdata; drd = d_rdata;
    end
  endtask

  task automatic test_reset();
    #2;
    asserts++;
    if (m_req !== 1'b0) begin
      fails++; $display("FAIL reset_m_req got %0b exp 0", m_req);
    end
    asserts++;
    if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 4'b0) begin
      fails++;
      $display("FAIL reset_oks got %b exp 0000",
               {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
    end
    asserts++;
    if (m_addr !== 32'h0 || i_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_data got %h/%h exp 0/0", m_addr, i_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    i_req = 1; i_addr = 32'hBFC00000;
    #1;
    asserts++;
    if (m_req !== 1'b0) begin
      fails++; $display("FAIL fetch_c0_m_req got %0b exp 0", m_req);
    end
    @(negedge clk);
    m_addr_ok = 1;
    #1;
    asserts++;
    if (m_req !== 1'b1 || m_addr !== 32'hBFC00000) begin
      fails++; $display("FAIL fetch_c1_req got %0b %h exp 1 bfc00000", m_req, m_addr);
    end
    asserts++;
    if (m_wr !== 1'b0 || m_size !== 2'd2 || m_wstrb !== 4'h0) begin
      fails++;
      $display("FAIL fetch_c1_attr got %0b %0d %h exp 0 2 0", m_wr, m_size, m_wstrb);
    end
    asserts++;
    if (i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL fetch_c1_aok got i%0b d%0b exp i1 d0", i_addr_ok, d_addr_ok);
    end
    @(negedge clk);
    i_req = 0; m_addr_ok = 0;
    #1;
    asserts++;
    if (m_req !== 1'b0 || i_data_ok !== 1'b0) begin
      fails++;
      $display("FAIL fetch_c2 got req%0b dok%0b exp 0 0", m_req, i_data_ok);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h3C080001;
    #1;
    asserts++;
    if (i_data_ok !== 1'b1 || i_rdata !== 32'h3C080001) begin
      fails++;
      $display("FAIL fetch_c3_data got %0b %h exp 1 3c080001", i_data_ok, i_rdata);
    end
    asserts++;
    if (d_data_ok !== 1'b0 || d_rdata !== 32'h0) begin
      fails++; $display("FAIL fetch_c3_d got %0b %h exp 0 0", d_data_ok, d_rdata);
    end
    @(negedge clk);
    m_data_ok = 0;
    #1;
    asserts++;
    if (m_req !== 1'b0 || i_data_ok !== 1'b0) begin
      fails++; $display("FAIL fetch_c4_idle got %0b %0b exp 0 0", m_req, i_data_ok);
    end
  endtask

  task automatic test_contention();
    logic to, wr, iaok, daok, idok, ddok;
    int w;
    logic [31:0] a, wd, ird, drd;
    logic [1:0] sz;
    logic [3:0] st;
    @(negedge clk);
    i_req = 1; i_addr = 32'hBFC00004;
    d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80000010;
    serve(32'hCAFE0001, to, w, a, wr, sz, st, wd, iaok, daok, idok, ddok, ird, drd);
    d_req = 0;
    asserts++;
    if (to !== 1'b0 || w != 0 || a !== 32'h80000010) begin
      fails++;
      $display("FAIL cont_first got to%0b w%0d %h exp 0 0 80000010", to, w, a);
    end
    asserts++;
    if ({daok, iaok, ddok, idok} !== 4'b1010 || drd !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL cont_first_ok got %b %h exp 1010 cafe0001",
               {daok, iaok, ddok, idok}, drd);
    end
    serve(32'h11112222, to, w, a, wr, sz, st, wd, iaok, daok, idok, ddok, ird, drd);
    i_req = 0;
    asserts++;
    if (to !== 1'b0 || w != 1 || a !== 32'hBFC00004) begin
      fails++;
      $display("FAIL cont_fetch got to%0b w%0d %h exp 0 1 bfc00004", to, w, a);
    end
    asserts++;
    if ({iaok, idok, daok, ddok} !== 4'b1100 || ird !== 32'h11112222) begin
      fails++;
      $display("FAIL cont_fetch_ok got %b %h exp 1100 11112222",
               {iaok, idok, daok, ddok}, ird);
    end
  endtask

  task automatic test_starvation();
    logic to, wr, iaok, daok, idok, ddok, exp_f;
    int w;
    logic [31:0] a, wd, ird, drd;
    logic [1:0] sz;
    logic [3:0] st;
    @(negedge clk);
    m_data_ok = 0;
    i_req = 1; i_addr = 32'hBFC00200;
    d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80000400;
    for (int k = 0; k < 10; k++) begin
      serve(32'(k), to, w, a, wr, sz, st, wd, iaok, daok, idok, ddok, ird, drd);
      exp_f = (k == 4 || k == 9);
      asserts++;
      if (to !== 1'b0 || a !== (exp_f ? 32'hBFC00200 : 32'h80000400) ||
          iaok !== exp_f || daok !== !exp_f) begin
        fails++;
        $display("FAIL starve_grant%0d got to%0b %h i%0b d%0b exp fetch=%0b",
                 k, to, a, iaok, daok, exp_f);
      end
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_cancel();
    logic to, wr, iaok, daok, idok, ddok;
    int w;
    logic [31:0] a, wd, ird, drd;
    logic [1:0] sz;
    logic [3:0] st;
    @(negedge clk);
    m_data_ok = 0;
    i_req = 1; i_addr = 32'hBFC00100;
    @(negedge clk);
    #1;
    asserts++;
    if (m_req !== 1'b1) begin
      fails++; $display("FAIL cancel_addr got %0b exp 1", m_req);
    end
    m_addr_ok = 1;
    @(negedge clk);
    i_req = 0; m_addr_ok = 0; i_cancel = 1;
    #1;
    asserts++;
    if (i_data_ok !== 1'b0 || m_req !== 1'b0) begin
      fails++; $display("FAIL cancel_data got %0b %0b exp 0 0", i_data_ok, m_req);
    end
    @(negedge clk);
    i_cancel = 0; m_data_ok = 1; m_rdata = 32'h12345678;
    #1;
    asserts++;
    if (i_data_ok !== 1'b0 || i_rdata !== 32'h0 || d_data_ok !== 1'b0) begin
      fails++;
      $display("FAIL cancel_drop got %0b %h %0b exp 0 0 0", i_data_ok, i_rdata, d_data_ok);
    end
    @(negedge clk);
    m_data_ok = 0;
    #1;
    asserts++;
    if (m_req !== 1'b0) begin
      fails++; $display("FAIL cancel_idle got %0b exp 0", m_req);
    end
    i_req = 1; i_addr = 32'hBFC00104;
    serve(32'hAABBCCDD, to, w, a, wr, sz, st, wd, iaok, daok, idok, ddok, ird, drd);
    i_req = 0;
    asserts++;
    if (to !== 1'b0 || iaok !== 1'b1 || idok !== 1'b1 || ird !== 32'hAABBCCDD) begin
      fails++;
      $display("FAIL cancel_next got to%0b a%0b d%0b %h exp 0 1 1 aabbccdd",
               to, iaok, idok, ird);
    end
  endtask

  task automatic test_store();
    logic to, wr, iaok, daok, idok, ddok;
    int w;
    logic [31:0] a, wd, ird, drd;
    logic [1:0] sz;
    logic [3:0] st;
    @(negedge clk);
    m_data_ok = 0;
    d_req = 1; d_wr = 1; d_size = 2'd1; d_wstrb = 4'b0011;
    d_addr = 32'h80001002; d_wdata = 32'h0000BEEF;
    serve(32'h0, to, w, a, wr, sz, st, wd, iaok, daok, idok, ddok, ird, drd);
    d_req = 0; d_wr = 0; d_wstrb = 0;
    asserts++;
    if (to !== 1'b0 || wr !== 1'b1 || sz !== 2'd1 || st !== 4'b0011) begin
      fails++;
      $display("FAIL store_attr got to%0b %0b %0d %b exp 0 1 1 0011", to, wr, sz, st);
    end
    asserts++;
    if (a !== 32'h80001002 || wd !== 32'h0000BEEF) begin
      fails++; $display("FAIL store_addr got %h %h exp 80001002 0000beef", a, wd);
    end
    asserts++;
    if (daok !== 1'b1 || ddok !== 1'b1 || idok !== 1'b0) begin
      fails++; $display("FAIL store_ok got %0b %0b %0b exp 1 1 0", daok, ddok, idok);
    end
  endtask

  task automatic test_reset_mid();
    logic to, wr, iaok, daok, idok, ddok;
    int w;
    logic [31:0] a, wd, ird, drd;
    logic [1:0] sz;
    logic [3:0] st;
    @(negedge clk);
    m_data_ok = 0;
    i_req = 1; i_addr = 32'hBFC00300;
    @(negedge clk);
    m_addr_ok = 1;
    @(negedge clk);
    m_addr_ok = 0; i_req = 0; m_data_ok = 1; m_rdata = 32'h55AA55AA;
    #1;
    asserts++;
    if (i_data_ok !== 1'b1) begin
      fails++; $display("FAIL rst_pre got %0b exp 1", i_data_ok);
    end
    resetn = 0;
    #1;
    asserts++;
    if ({m_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 5'b0) begin
      fails++;
      $display("FAIL rst_async got %b exp 00000",
               {m_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
    end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    #1;
    asserts++;
    if ({m_req, i_data_ok, d_data_ok} !== 3'b0 || i_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_stray got %b %h exp 000 0",
               {m_req, i_data_ok, d_data_ok}, i_rdata);
    end
    m_data_ok = 0; m_addr_ok = 1;
    @(negedge clk);
    m_addr_ok = 0;
    #1;
    asserts++;
    if (m_req !== 1'b0 || i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0) begin
      fails++; $display("FAIL rst_stray_aok got %0b exp 0", m_req);
    end
    d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80000020;
    serve(32'h0BADF00D, to, w, a, wr, sz, st, wd, iaok, daok, idok, ddok, ird, drd);
    d_req = 0;
    asserts++;
    if (to !== 1'b0 || ddok !== 1'b1 || drd !== 32'h0BADF00D || a !== 32'h80000020) begin
      fails++;
      $display("FAIL rst_after got to%0b %0b %h %h exp 0 1 0badf00d 80000020",
               to, ddok, drd, a);
    end
    @(negedge clk);
    m_data_ok = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_starvation();
    test_cancel();
    test_store();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
